// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes and sequencer FSM states.
package calc1_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } calc_cmd_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    OVF     = 2'd2,
    INVALID = 2'd3
  } calc_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND1,
    ST_SEND2,
    ST_WAIT,
    ST_HOLD
  } seq_state_t;

endpackage

// File: rtl/calc1_port_sequencer_if.sv
// Request, response and calc1-port signal bundle for the port sequencer.
interface calc1_port_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
);
  // upstream request handshake
  logic              req_valid;
  logic              req_ready;
  logic [0:CMD_W-1]  req_cmd;
  logic [0:DATA_W-1] req_op1;
  logic [0:DATA_W-1] req_op2;
  // downstream result handshake
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:1]        rsp_code;
  logic              rsp_err;
  logic [0:DATA_W-1] rsp_data;
  // calc1 port
  logic [0:CMD_W-1]  calc_cmd;
  logic [0:DATA_W-1] calc_data;
  logic [0:1]        calc_resp;
  logic [0:DATA_W-1] calc_rdata;
  logic              spurious_resp;

  // Requester / consumer / calc1 side.
  modport master (
    output req_valid, req_cmd, req_op1, req_op2, rsp_ready, calc_resp, calc_rdata,
    input  req_ready, rsp_valid, rsp_code, rsp_err, rsp_data, calc_cmd, calc_data,
           spurious_resp
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_cmd, req_op1, req_op2, rsp_ready, calc_resp, calc_rdata,
    output req_ready, rsp_valid, rsp_code, rsp_err, rsp_data, calc_cmd, calc_data,
           spurious_resp
  );
endinterface

// File: rtl/calc1_port_sequencer_wait_timer.sv
// Clear/enable WAIT-cycle counter with a terminal-count flag at TIMEOUT-1.
module calc1_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg;

  assign tc = (count_reg == CNT_W'(TIMEOUT - 1));

  // Count WAIT cycles; hold at terminal count until the owner leaves WAIT.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !tc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/calc1_port_sequencer.sv
// Replays one captured request onto the calc1 two-cycle port, waits for the
// response (with timeout) and holds the result on a valid/ready output.
module calc1_port_sequencer
  import calc1_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic c_clk,
  input logic reset,
  calc1_port_sequencer_if.slave bus
);
  seq_state_t        state_reg, state_next;
  logic [0:DATA_W-1] op2_reg;
  logic [0:CMD_W-1]  calc_cmd_reg, calc_cmd_next;
  logic [0:DATA_W-1] calc_data_reg, calc_data_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [0:1]        rsp_code_reg, rsp_code_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [0:DATA_W-1] rsp_data_reg, rsp_data_next;
  logic              spurious_reg;
  logic              accept, resp_seen, timer_tc;

  assign accept    = (state_reg == ST_IDLE) && bus.req_valid;
  assign resp_seen = (bus.calc_resp != '0);

  calc1_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .c_clk  (c_clk),
    .reset  (reset),
    .clear  (state_reg == ST_SEND2),
    .enable (state_reg == ST_WAIT),
    .tc     (timer_tc)
  );

  // State and registered outputs; op2 is kept for the second port cycle.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op2_reg       <= '0;
      calc_cmd_reg  <= '0;
      calc_data_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_code_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      spurious_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      if (accept) op2_reg <= bus.req_op2;
      calc_cmd_reg  <= calc_cmd_next;
      calc_data_reg <= calc_data_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_code_reg  <= rsp_code_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
      spurious_reg  <= spurious_reg | (resp_seen && state_reg != ST_WAIT);
    end
  end

  // Next-state: NOP requests skip the calc1 port and go straight to HOLD.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.req_valid) state_next = (bus.req_cmd != '0) ? ST_SEND1 : ST_HOLD;
      ST_SEND1: state_next = ST_SEND2;
      ST_SEND2: state_next = ST_WAIT;
      ST_WAIT:  if (resp_seen || timer_tc) state_next = ST_HOLD;
      ST_HOLD:  if (bus.rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output values for the next cycle; a response beats a same-cycle timeout.
  always_comb begin
    calc_cmd_next  = '0;
    calc_data_next = '0;
    rsp_valid_next = rsp_valid_reg;
    rsp_code_next  = rsp_code_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_data_next  = rsp_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_cmd != '0) begin
            calc_cmd_next  = bus.req_cmd;
            calc_data_next = bus.req_op1;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_code_next  = '0;
            rsp_err_next   = 1'b0;
            rsp_data_next  = '0;
          end
        end
      end
      ST_SEND1: calc_data_next = op2_reg;
      ST_WAIT: begin
        if (resp_seen) begin
          rsp_valid_next = 1'b1;
          rsp_code_next  = bus.calc_resp;
          rsp_err_next   = 1'b0;
          rsp_data_next  = bus.calc_rdata;
        end else if (timer_tc) begin
          rsp_valid_next = 1'b1;
          rsp_code_next  = '0;
          rsp_err_next   = 1'b1;
          rsp_data_next  = '0;
        end
      end
      ST_HOLD: if (bus.rsp_ready) rsp_valid_next = 1'b0;
      default: ;
    endcase
  end

  assign bus.req_ready     = (state_reg == ST_IDLE);
  assign bus.rsp_valid     = rsp_valid_reg;
  assign bus.rsp_code      = rsp_code_reg;
  assign bus.rsp_err       = rsp_err_reg;
  assign bus.rsp_data      = rsp_data_reg;
  assign bus.calc_cmd      = calc_cmd_reg;
  assign bus.calc_data     = calc_data_reg;
  assign bus.spurious_resp = spurious_reg;
endmodule

// File: tb/tb_calc1_port_sequencer.sv
// Scenario bench for calc1_port_sequencer: TIMEOUT=8 main instance plus a
// TIMEOUT=4 instance for the response/timeout race.
module tb_calc1_port_sequencer;
  import calc1_pkg::*;

  logic c_clk = 1'b0;
  logic reset;
  always #5 c_clk = ~c_clk;

  calc1_port_sequencer_if #(.DATA_W(32), .CMD_W(4)) bus ();
  calc1_port_sequencer_if #(.DATA_W(32), .CMD_W(4)) bus4 ();

  calc1_port_sequencer #(.DATA_W(32), .CMD_W(4), .TIMEOUT(8)) u_dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  calc1_port_sequencer #(.DATA_W(32), .CMD_W(4), .TIMEOUT(4)) u_dut4 (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    logic [1:0]  code;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp4_q[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] code, input logic err, input logic [31:0] data);
    rsp_t e;
    e.code = code; e.err = err; e.data = data;
    exp_q.push_back(e);
  endtask

  // Offer a request on the main instance and return just after the accept edge.
  task automatic accept(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready actual %b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_op1 = op1; bus.req_op2 = op2;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // calc1 model: present a response for one cycle.
  task automatic calc_respond(input logic [1:0] code, input logic [31:0] data);
    bus.calc_resp = code; bus.calc_rdata = data;
    tick();
    bus.calc_resp = 2'd0; bus.calc_rdata = 32'd0;
  endtask

  // Scoreboard drain: wait (bounded) for rsp_valid, compare to the oldest expectation, handshake.
  task automatic sb_drain(input string name, input int max_wait, output int waited);
    rsp_t e;
    waited = 0;
    while (!bus.rsp_valid && waited < max_wait) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_valid actual %b required 1 after %0d cycles", name, bus.rsp_valid, waited);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty actual 0 entries required 1", name);
    end else begin
      e = exp_q.pop_front();
      if ({bus.rsp_code, bus.rsp_err, bus.rsp_data} !== {e.code, e.err, e.data}) begin
        errors++;
        $display("FAIL %s rsp actual code=%0d err=%b data=%h required code=%0d err=%b data=%h",
                 name, bus.rsp_code, bus.rsp_err, bus.rsp_data, e.code, e.err, e.data);
      end
    end
    $display("rsp %s code=%0d err=%b data=%h wait=%0d", name, bus.rsp_code, bus.rsp_err, bus.rsp_data, waited);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake actual valid=%b ready=%b required valid=0 ready=1",
               name, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data,
         bus.calc_cmd, bus.calc_data, bus.spurious_resp} !== {1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state actual ready=%b valid=%b code=%0d err=%b data=%h cmd=%h cdata=%h spur=%b required 1/0/0/0/0/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data,
               bus.calc_cmd, bus.calc_data, bus.spurious_resp);
    end
    checks++;
    if ({bus4.req_ready, bus4.rsp_valid, bus4.calc_cmd} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state4 actual ready=%b valid=%b cmd=%h required 1/0/0",
               bus4.req_ready, bus4.rsp_valid, bus4.calc_cmd);
    end
    $display("txn reset done");
  endtask

  task automatic test_add();
    int w;
    push_exp(2'd1, 1'b0, 32'd3);
    accept(ADD, 32'h1, 32'h2);
    checks++;
    if ({bus.calc_cmd, bus.calc_data} !== {4'd1, 32'h1}) begin
      errors++;
      $display("FAIL add_send1 actual cmd=%h data=%h required cmd=1 data=00000001", bus.calc_cmd, bus.calc_data);
    end
    tick();
    checks++;
    if ({bus.calc_cmd, bus.calc_data} !== {4'd0, 32'h2}) begin
      errors++;
      $display("FAIL add_send2 actual cmd=%h data=%h required cmd=0 data=00000002", bus.calc_cmd, bus.calc_data);
    end
    tick();
    checks++;
    if ({bus.calc_cmd, bus.calc_data, bus.rsp_valid} !== {4'd0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL add_wait_port actual cmd=%h data=%h valid=%b required 0/0/0",
               bus.calc_cmd, bus.calc_data, bus.rsp_valid);
    end
    tick(); tick();
    calc_respond(2'd1, 32'd3);
    sb_drain("add", 0, w);
  endtask

  task automatic test_nop();
    int w;
    push_exp(2'd0, 1'b0, 32'd0);
    accept(NOP, 32'h9, 32'h9);
    checks++;
    if ({bus.calc_cmd, bus.calc_data} !== {4'd0, 32'd0}) begin
      errors++;
      $display("FAIL nop_port actual cmd=%h data=%h required 0/0", bus.calc_cmd, bus.calc_data);
    end
    sb_drain("nop", 0, w);
  endtask

  task automatic test_timeout();
    int w;
    push_exp(2'd0, 1'b1, 32'd0);
    accept(SUB, 32'h5, 32'h6);
    sb_drain("timeout", 20, w);
    checks++;
    if (w != 10) begin
      errors++;
      $display("FAIL timeout_latency actual %0d required 10 cycles after accept", w);
    end
  endtask

  task automatic test_backpressure();
    int w;
    rsp_t e;
    push_exp(2'd1, 1'b0, 32'd7);
    accept(SUB, 32'd10, 32'd3);
    tick(); tick();
    calc_respond(2'd1, 32'd7);
    bus.req_valid = 1'b1; bus.req_cmd = ADD; bus.req_op1 = 32'd100; bus.req_op2 = 32'd200;
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data, bus.req_ready, bus.calc_cmd} !==
          {1'b1, e.code, e.err, e.data, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL bp_hold%0d actual valid=%b code=%0d err=%b data=%h ready=%b cmd=%h required 1/%0d/%b/%h/0/0",
                 i, bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data, bus.req_ready, bus.calc_cmd,
                 e.code, e.err, e.data);
      end
      tick();
    end
    $display("rsp bp code=%0d err=%b data=%h held 5 cycles", bus.rsp_code, bus.rsp_err, bus.rsp_data);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.calc_cmd} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL bp_release actual ready=%b valid=%b cmd=%h required 1/0/0",
               bus.req_ready, bus.rsp_valid, bus.calc_cmd);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.calc_cmd, bus.calc_data} !== {4'd1, 32'd100}) begin
      errors++;
      $display("FAIL bp_second_accept actual cmd=%h data=%h required 1/00000064", bus.calc_cmd, bus.calc_data);
    end
    push_exp(2'd1, 1'b0, 32'd300);
    tick(); tick();
    calc_respond(2'd1, 32'd300);
    sb_drain("bp_second", 0, w);
  endtask

  task automatic test_invalid();
    int w;
    push_exp(2'd3, 1'b0, 32'd9);
    accept(4'hF, 32'h1, 32'h1);
    checks++;
    if (bus.calc_cmd !== 4'hF) begin
      errors++;
      $display("FAIL invalid_forward actual cmd=%h required f", bus.calc_cmd);
    end
    tick(); tick();
    calc_respond(2'd3, 32'd9);
    sb_drain("invalid", 0, w);
  endtask

  task automatic test_race();
    rsp_t e;
    e.code = 2'd2; e.err = 1'b0; e.data = 32'hDEAD;
    exp4_q.push_back(e);
    bus4.req_valid = 1'b1; bus4.req_cmd = ADD; bus4.req_op1 = 32'h7FFF_FFFF; bus4.req_op2 = 32'h1;
    tick();
    bus4.req_valid = 1'b0;
    tick(); tick();
    tick(); tick(); tick();
    bus4.calc_resp = 2'd2; bus4.calc_rdata = 32'hDEAD;
    tick();
    bus4.calc_resp = 2'd0; bus4.calc_rdata = 32'd0;
    e = exp4_q.pop_front();
    checks++;
    if ({bus4.rsp_valid, bus4.rsp_code, bus4.rsp_err, bus4.rsp_data} !== {1'b1, e.code, e.err, e.data}) begin
      errors++;
      $display("FAIL race_rsp actual valid=%b code=%0d err=%b data=%h required 1/%0d/%b/%h",
               bus4.rsp_valid, bus4.rsp_code, bus4.rsp_err, bus4.rsp_data, e.code, e.err, e.data);
    end
    $display("rsp race code=%0d err=%b data=%h", bus4.rsp_code, bus4.rsp_err, bus4.rsp_data);
    bus4.rsp_ready = 1'b1;
    tick();
    bus4.rsp_ready = 1'b0;
    checks++;
    if ({bus4.rsp_valid, bus4.req_ready, bus4.spurious_resp} !== {1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL race_release actual valid=%b ready=%b spur=%b required 0/1/0",
               bus4.rsp_valid, bus4.req_ready, bus4.spurious_resp);
    end
  endtask

  task automatic test_reset_in_wait();
    accept(ADD, 32'd7, 32'd8);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data,
         bus.calc_cmd, bus.calc_data, bus.spurious_resp} !== {1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait_state actual ready=%b valid=%b code=%0d err=%b data=%h cmd=%h cdata=%h spur=%b required 1/0/0/0/0/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_code, bus.rsp_err, bus.rsp_data,
               bus.calc_cmd, bus.calc_data, bus.spurious_resp);
    end
    tick();
    calc_respond(2'd1, 32'd15);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.spurious_resp, bus.rsp_valid} !== {1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rst_wait_spurious%0d actual spur=%b valid=%b required 1/0",
                 i, bus.spurious_resp, bus.rsp_valid);
      end
      tick();
    end
    $display("txn late response flagged spur=%b", bus.spurious_resp);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.spurious_resp !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear_spurious actual %b required 0", bus.spurious_resp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_cmd = 4'd0; bus.req_op1 = 32'd0; bus.req_op2 = 32'd0;
    bus.rsp_ready = 1'b0; bus.calc_resp = 2'd0; bus.calc_rdata = 32'd0;
    bus4.req_valid = 1'b0; bus4.req_cmd = 4'd0; bus4.req_op1 = 32'd0; bus4.req_op2 = 32'd0;
    bus4.rsp_ready = 1'b0; bus4.calc_resp = 2'd0; bus4.calc_rdata = 32'd0;

    test_reset();
    test_add();
    test_nop();
    test_timeout();
    test_backpressure();
    test_invalid();
    test_race();
    test_reset_in_wait();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/calc1_port_sequencer.md
# calc1_port_sequencer

Upstream request sequencer for one calc1 port. It accepts a complete calculation request (command plus two operands) over a valid/ready handshake and replays it onto the calc1 two-cycle port protocol. It then waits for the calc1 response, with a timeout, and presents the result over a downstream valid/ready handshake. Stimulus generators and bus adapters use it so they never hand-sequence the calc1 port themselves.

## Interface
- DATA_W, 32, operand/result width
- CMD_W, 4, command width
- TIMEOUT, 64, maximum WAIT cycles before abandoning a request (≥2)

- c_clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  sequencer can accept
- req_cmd  in  [0:3]  calc1 command
- req_op1  in  [0:31]  first operand
- req_op2  in  [0:31]  second operand
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_code  out  [0:1]  calc1 response code, or 0 on timeout/no-op
- rsp_err  out  1  timeout indication
- rsp_data  out  [0:31]  result data
- calc_cmd  out  [0:3]  to calc1 cmd_in
- calc_data  out  [0:31]  to calc1 data_in
- calc_resp  in  [0:1]  from calc1 out_resp
- calc_rdata  in  [0:31]  from calc1 out_data
- spurious_resp  out  1  sticky: nonzero calc_resp seen outside WAIT

## Operation
- FSM states:
  - IDLE
    - req_ready=1.
    - req_valid&&req_ready captures cmd/op1/op2.
    - cmd≠0 → SEND1.
    - cmd=0 → HOLD with rsp_code=0, rsp_err=0, rsp_data=0; calc port untouched.
  - SEND1: calc_cmd=cmd, calc_data=op1 → SEND2.
  - SEND2: calc_cmd=0, calc_data=op2 → WAIT; wait counter cleared.
  - WAIT
    - calc_cmd=0, calc_data=0.
    - calc_resp≠0: capture calc_resp→rsp_code and calc_rdata→rsp_data; rsp_err=0; → HOLD.
    - Otherwise increment counter. If the counter reaches TIMEOUT-1 → HOLD with rsp_code=0, rsp_data=0, rsp_err=1.
  - HOLD
    - rsp_valid=1; rsp_* stable.
    - rsp_ready → IDLE.
- Commands are forwarded unmodified; invalid codes are left for calc1 to answer (it returns code 3).
- calc_resp is ignored for result purposes outside WAIT. Any nonzero value outside WAIT sets spurious_resp, which is cleared only by reset.
- Response in the same cycle the counter hits TIMEOUT-1: the response wins, rsp_err=0.
- One request in flight; no queueing.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE; req_ready=1 (combinational from state).
  - rsp_valid=0, rsp_code=0, rsp_err=0, rsp_data=0.
  - calc_cmd=0, calc_data=0.
  - spurious_resp=0; counter 0.
- Accept at edge E0. At E0+1 calc1 sees cmd/op1; at E0+2 it sees 0/op2; from E0+3 it sees 0/0.
- Response sampled in WAIT cycle k → rsp_valid high from the next cycle.
- Timeout → rsp_valid asserted exactly TIMEOUT WAIT cycles after entering WAIT.
- rsp_valid && rsp_ready at edge → IDLE; req_ready=1 in the following cycle (minimum 1 IDLE cycle between requests).
- Reset mid-operation:
  - Next edge returns all outputs to reset values, including calc_cmd=0.
  - The pending result is discarded and calc1 is not reset.
  - A late calc1 response then sets spurious_resp.

## Structure
- Shared package calc1_pkg:
  - Command constants: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - Response constants: NONE=0, OK=1, OVF=2, INVALID=3.
  - FSM state enum.
- One sub-module, calc1_wait_timer: clear/enable counter with a terminal-count flag at TIMEOUT-1.

## Test plan
- Add path: req ADD, 32'h1, 32'h2; model returns resp=1, data=3 in the 3rd WAIT cycle → port sees (1,32'h1), then (0,32'h2); rsp_valid with code 1, data 3, err 0.
- Timeout: TIMEOUT=8, model silent → rsp_valid exactly 8 WAIT cycles after SEND2; code 0, err 1, data 0.
- Backpressure: rsp_ready low 5 cycles with req_valid held → rsp_* stable, req_ready=0, no second accept; the request is accepted one cycle after the rsp handshake.
- NOP: req_cmd=0 → calc_cmd stays 0; rsp_valid the cycle after accept with code 0, err 0.
- Reset in WAIT: assert reset one cycle → IDLE, all outputs at reset values, no rsp_valid; model response 2 cycles later → spurious_resp=1, held until the next reset.
- Race: TIMEOUT=4, response in the 4th WAIT cycle → code from calc1, err 0.
